// File: rtl/qlf_k6n10f_pipe_alu_pkg.sv
// Shared op encodings and segment-geometry helpers for the pipelined
// add/sub/accumulate unit.
package qlf_k6n10f_pipe_alu_pkg;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_ACC    = 2'b10;
  localparam logic [1:0] OP_ACCSUB = 2'b11;

  function automatic int nseg(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

  // The top segment only covers whatever bits remain above the full ones.
  function automatic int seg_bits(input int width, input int seg, input int k);
    int rem;
    rem = width - k * seg;
    return (rem < seg) ? rem : seg;
  endfunction

endpackage

// File: rtl/qlf_k6n10f_alu_seg.sv
// One pipeline stage: a BITS-wide ripple carry chain with its own slice of the
// accumulator, registered carry/overflow and the stage valid/op tags.
module qlf_k6n10f_alu_seg
  import qlf_k6n10f_pipe_alu_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            clock_i,
  input  logic            reset_n_i,
  input  logic            en_i,
  input  logic            valid_i,
  input  logic [1:0]      op_i,
  input  logic            clr_i,
  input  logic            carry_i,
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  output logic [BITS-1:0] sum_o,
  output logic            valid_o,
  output logic [1:0]      op_o,
  output logic            clr_o,
  output logic            carry_o,
  output logic            ov_o
);

  logic            isAcc;
  logic            invert;
  logic [BITS-1:0] xOp;
  logic [BITS-1:0] yOp;
  logic [BITS-1:0] sum;
  logic [BITS:0]   cy;

  logic            valid_q;
  logic [1:0]      op_q;
  logic            clr_q;
  logic            carry_q;
  logic            ov_q;
  logic [BITS-1:0] acc_q;

  // Accumulating ops add A to the held accumulator; plain ops add A to B.
  always_comb begin
    isAcc  = (op_i == OP_ACC) || (op_i == OP_ACCSUB);
    invert = (op_i == OP_SUB) || (op_i == OP_ACCSUB);
    xOp    = isAcc ? (clr_i ? '0 : acc_q) : a_i;
    yOp    = isAcc ? a_i : b_i;
    if (invert) yOp = ~yOp;
    sum    = '0;
    cy     = '0;
    cy[0]  = carry_i;
    for (int i = 0; i < BITS; i++) begin
      sum[i]   = xOp[i] ^ yOp[i] ^ cy[i];
      cy[i+1]  = (xOp[i] & yOp[i]) | (cy[i] & (xOp[i] ^ yOp[i]));
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= 1'b0;
      op_q    <= OP_ADD;
      clr_q   <= 1'b0;
      carry_q <= 1'b0;
      ov_q    <= 1'b0;
      acc_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      op_q    <= op_i;
      clr_q   <= clr_i;
      if (valid_i) begin
        carry_q <= cy[BITS];
        ov_q    <= cy[BITS] ^ cy[BITS-1];
        if (isAcc) acc_q <= sum;
      end
    end
  end

  assign sum_o   = sum;
  assign valid_o = valid_q;
  assign op_o    = op_q;
  assign clr_o   = clr_q;
  assign carry_o = carry_q;
  assign ov_o    = ov_q;

endmodule

// File: rtl/qlf_k6n10f_pipe_alu.sv
// Pipelined WIDTH-bit add/sub/accumulate: one segment per stage, operands
// skewed on accept, result bits collected as the operation walks the stages.
module qlf_k6n10f_pipe_alu
  import qlf_k6n10f_pipe_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic             acc_clr_i,
  input  logic             ci_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic             co_o,
  output logic             ov_o
);

  localparam int NSEG = nseg(WIDTH, SEG_WIDTH);

  logic             advance;
  logic             frontValid_q;
  logic [1:0]       frontOp_q;
  logic             frontClr_q;
  logic             frontCi_q;

  logic             stValid [NSEG];
  logic [1:0]       stOp    [NSEG];
  logic             stClr   [NSEG];
  logic             stCarry [NSEG];
  logic [NSEG-1:0]  stOv;
  logic [WIDTH-1:0] resStage [NSEG];
  logic             unusedTail;

  assign advance    = !(out_valid_o && !out_ready_i);
  assign in_ready_o = advance;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      frontValid_q <= 1'b0;
      frontOp_q    <= OP_ADD;
      frontClr_q   <= 1'b0;
      frontCi_q    <= 1'b0;
    end else if (advance) begin
      frontValid_q <= in_valid_i;
      frontOp_q    <= op_i;
      frontClr_q   <= acc_clr_i;
      frontCi_q    <= ci_i;
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO   = k * SEG_WIDTH;
    localparam int BITS = seg_bits(WIDTH, SEG_WIDTH, k);

    logic [BITS-1:0]  aDly_q [k+1];
    logic [BITS-1:0]  bDly_q [k+1];
    logic             validIn;
    logic [1:0]       opIn;
    logic             clrIn;
    logic             carryIn;
    logic [WIDTH-1:0] resIn;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;
    logic [BITS-1:0]  sum;

    if (k == 0) begin : g_head
      // Stage 0 seeds the chain: ci for ADD, +1 for the two subtracting ops.
      assign validIn = frontValid_q;
      assign opIn    = frontOp_q;
      assign clrIn   = frontClr_q;
      assign carryIn = (frontOp_q == OP_ADD) ? frontCi_q : frontOp_q[0];
      assign resIn   = '0;
    end else begin : g_body
      assign validIn = stValid[k-1];
      assign opIn    = stOp[k-1];
      assign clrIn   = stClr[k-1];
      assign carryIn = stCarry[k-1];
      assign resIn   = resStage[k-1];
    end

    // Segment k must wait k+1 advances so it meets its carry at stage k.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        for (int j = 0; j <= k; j++) begin
          aDly_q[j] <= '0;
          bDly_q[j] <= '0;
        end
      end else if (advance) begin
        aDly_q[0] <= a_i[LO +: BITS];
        bDly_q[0] <= b_i[LO +: BITS];
        for (int j = 1; j <= k; j++) begin
          aDly_q[j] <= aDly_q[j-1];
          bDly_q[j] <= bDly_q[j-1];
        end
      end
    end

    qlf_k6n10f_alu_seg #(.BITS(BITS)) u_seg (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .en_i      (advance),
      .valid_i   (validIn),
      .op_i      (opIn),
      .clr_i     (clrIn),
      .carry_i   (carryIn),
      .a_i       (aDly_q[k]),
      .b_i       (bDly_q[k]),
      .sum_o     (sum),
      .valid_o   (stValid[k]),
      .op_o      (stOp[k]),
      .clr_o     (stClr[k]),
      .carry_o   (stCarry[k]),
      .ov_o      (stOv[k])
    );

    always_comb begin
      res_d            = resIn;
      res_d[LO +: BITS] = sum;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) res_q <= '0;
      else if (advance && validIn) res_q <= res_d;
    end

    assign resStage[k] = res_q;
  end

  assign out_valid_o = stValid[NSEG-1];
  assign res_o       = resStage[NSEG-1];
  assign co_o        = stCarry[NSEG-1];
  assign ov_o        = stOv[NSEG-1];

  // Op/clr tags and lower-stage overflow have no consumer past the last stage.
  assign unusedTail = ^{stOv, stOp[NSEG-1], stClr[NSEG-1]};

endmodule

// File: tb/tb_qlf_k6n10f_pipe_alu.sv
// Randomized and directed bench for qlf_k6n10f_pipe_alu (32/8 and 20/8 builds)
// against an arithmetic reference model and an in-order scoreboard.
module tb_qlf_k6n10f_pipe_alu;

  localparam int W  = 32;
  localparam int WN = 20;

  typedef struct packed {
    logic [63:0] res;
    logic        co;
    logic        ov;
  } result_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          inValid, inReady, accClr, ci, outValid, co, ov;
  logic          outReady = 1'b1;
  logic [1:0]    op;
  logic [W-1:0]  a, b, res;

  logic          nInValid, nInReady, nAccClr, nCi, nOutValid, nOutReady, nCo, nOv;
  logic [1:0]    nOp;
  logic [WN-1:0] nA, nB, nRes;

  int          checkCount = 0;
  int          errorCount = 0;
  int          popCount = 0;
  int          readyMode = 0;
  bit          monitorOn = 0;
  result_t     expQ[$];
  logic [63:0] accModel = '0;
  logic [W-1:0] lastStallRes = '0;
  bit          wasStalled = 0;
  logic [31:0] accExp [4];

  qlf_k6n10f_pipe_alu #(.WIDTH(W), .SEG_WIDTH(8)) dut (
    .clock_i(clock), .reset_n_i(reset_n), .in_valid_i(inValid), .in_ready_o(inReady),
    .op_i(op), .acc_clr_i(accClr), .ci_i(ci), .a_i(a), .b_i(b),
    .out_valid_o(outValid), .out_ready_i(outReady), .res_o(res), .co_o(co), .ov_o(ov)
  );

  qlf_k6n10f_pipe_alu #(.WIDTH(WN), .SEG_WIDTH(8)) dutNarrow (
    .clock_i(clock), .reset_n_i(reset_n), .in_valid_i(nInValid), .in_ready_o(nInReady),
    .op_i(nOp), .acc_clr_i(nAccClr), .ci_i(nCi), .a_i(nA), .b_i(nB),
    .out_valid_o(nOutValid), .out_ready_i(nOutReady), .res_o(nRes), .co_o(nCo), .ov_o(nOv)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Plain-arithmetic reference: x + z + c in 64 bits, then mask to width w.
  function automatic result_t refModel(input int w, input logic [1:0] opCode, input logic cin,
                                       input logic [63:0] opA, input logic [63:0] opB,
                                       input logic [63:0] accVal);
    logic [63:0] mask, x, z, full;
    logic        c;
    result_t     r;
    mask = (64'd1 << w) - 64'd1;
    case (opCode)
      2'b00:   begin x = opA;    z = opB;          c = cin;  end
      2'b01:   begin x = opA;    z = ~opB & mask;  c = 1'b1; end
      2'b10:   begin x = accVal; z = opA;          c = 1'b0; end
      default: begin x = accVal; z = ~opA & mask;  c = 1'b1; end
    endcase
    full  = x + z + {63'd0, c};
    r.res = full & mask;
    r.co  = full[w];
    r.ov  = (x[w-1] == z[w-1]) && (r.res[w-1] != x[w-1]);
    return r;
  endfunction

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Downstream ready: 0 = always ready, 1 = random, 2 = held off.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (readyMode)
        0:       outReady = 1'b1;
        1:       outReady = ($urandom_range(3) != 0);
        default: outReady = 1'b0;
      endcase
    end
  end

  // Scoreboard: push on accept, pop on output handshake, judged between edges.
  always @(negedge clock) begin
    result_t r;
    if (!reset_n) begin
      expQ.delete();
      accModel   = '0;
      wasStalled = 0;
    end else if (monitorOn) begin
      checkOutput("in_ready", {63'd0, inReady}, {63'd0, !(outValid && !outReady)});
      if (wasStalled) checkOutput("stall_hold", res, lastStallRes);
      if (inValid && inReady) begin
        r = refModel(W, op, ci, a, b, accClr ? 64'd0 : accModel);
        if (op[1]) accModel = r.res;
        expQ.push_back(r);
      end
      if (outValid && outReady) begin
        checkOutput("result_expected", {63'd0, expQ.size() > 0}, 64'd1);
        if (expQ.size() > 0) begin
          r = expQ.pop_front();
          checkOutput("res", res, r.res);
          checkOutput("co", {63'd0, co}, {63'd0, r.co});
          checkOutput("ov", {63'd0, ov}, {63'd0, r.ov});
          popCount++;
        end
      end
      wasStalled   = outValid && !outReady;
      lastStallRes = res;
    end
  end

  task automatic applyStimulus(input logic [1:0] opCode, input logic clr, input logic cin,
                               input logic [W-1:0] opA, input logic [W-1:0] opB);
    bit accepted = 0;
    op = opCode; accClr = clr; ci = cin; a = opA; b = opB; inValid = 1'b1;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clock);
      accepted = inReady;
      @(posedge clock);
      #1;
    end
    checkOutput("accepted", {63'd0, accepted}, 64'd1);
  endtask

  task automatic waitOutValid(output int lat);
    lat = 0;
    while (!outValid && lat < 50) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic runSingle(input string tag, input logic [1:0] opc, input logic clr, input logic cin,
                           input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] expRes, input logic expCo, input logic expOv);
    int lat;
    applyStimulus(opc, clr, cin, x, y);
    inValid = 1'b0;
    waitOutValid(lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'd4);
    checkOutput({tag, "_res"}, res, expRes);
    checkOutput({tag, "_co"}, {63'd0, co}, {63'd0, expCo});
    checkOutput({tag, "_ov"}, {63'd0, ov}, {63'd0, expOv});
    @(posedge clock);
    #1;
    checkOutput({tag, "_valid_drop"}, {63'd0, outValid}, 64'd0);
    checkOutput({tag, "_res_hold"}, res, expRes);
  endtask

  task automatic narrowCheck(input string tag, input logic [1:0] opc, input logic cin,
                             input logic [WN-1:0] x, input logic [WN-1:0] y,
                             input logic [WN-1:0] expRes, input logic expCo, input logic expOv);
    int lat = 0;
    checkOutput({tag, "_ready"}, {63'd0, nInReady}, 64'd1);
    nOp = opc; nCi = cin; nA = x; nB = y; nInValid = 1'b1;
    @(posedge clock);
    #1;
    nInValid = 1'b0;
    while (!nOutValid && lat < 50) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd3);
    checkOutput({tag, "_res"}, nRes, expRes);
    checkOutput({tag, "_co"}, {63'd0, nCo}, {63'd0, expCo});
    checkOutput({tag, "_ov"}, {63'd0, nOv}, {63'd0, expOv});
    @(posedge clock);
    #1;
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 200 && (expQ.size() != 0 || outValid); n++) begin
      @(posedge clock);
      #1;
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    result_t     r;
    logic [1:0]  opc;
    logic [W-1:0] x, y;
    int          lat;
    int          popBase;

    reset_n = 1'b0;
    inValid = 1'b0; op = 2'b00; accClr = 1'b0; ci = 1'b0; a = '0; b = '0;
    nInValid = 1'b0; nOp = 2'b00; nAccClr = 1'b0; nCi = 1'b0; nA = '0; nB = '0; nOutReady = 1'b1;
    accExp = '{32'h0000_00FF, 32'h0000_01FE, 32'h0000_02FD, 32'h0000_01FD};

    #12;
    checkOutput("reset_out_valid", {63'd0, outValid}, 64'd0);
    checkOutput("reset_res", res, 64'd0);
    checkOutput("reset_co_ov", {62'd0, co, ov}, 64'd0);
    checkOutput("reset_in_ready", {63'd0, inReady}, 64'd1);
    checkOutput("reset_narrow_valid", {63'd0, nOutValid}, 64'd0);
    #11;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    monitorOn = 1;

    $display("[TB] narrow 20/8 build");
    narrowCheck("n_add_wrap", 2'b00, 1'b0, 20'hFFFFF, 20'h00001, 20'h00000, 1'b1, 1'b0);
    narrowCheck("n_add_ov", 2'b00, 1'b0, 20'h7FFFF, 20'h00001, 20'h80000, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      opc = 2'($urandom_range(1));
      x = W'($urandom_range(20'hFFFFF));
      y = W'($urandom_range(20'hFFFFF));
      r = refModel(WN, opc, 1'b1, {32'd0, x}, {32'd0, y}, 64'd0);
      narrowCheck("n_rand", opc, 1'b1, x[WN-1:0], y[WN-1:0], r.res[WN-1:0], r.co, r.ov);
    end

    $display("[TB] directed add/sub");
    runSingle("add_wrap", 2'b00, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0);
    runSingle("sub_ov", 2'b01, 1'b0, 1'b0, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    runSingle("sub_borrow", 2'b01, 1'b0, 1'b1, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    $display("[TB] back-to-back accumulate");
    applyStimulus(2'b10, 1'b1, 1'b0, 32'hFF, 32'h0);
    applyStimulus(2'b10, 1'b0, 1'b0, 32'hFF, 32'h0);
    applyStimulus(2'b10, 1'b0, 1'b0, 32'hFF, 32'h0);
    applyStimulus(2'b11, 1'b0, 1'b0, 32'h100, 32'h0);
    inValid = 1'b0;
    waitOutValid(lat);
    for (int i = 0; i < 4; i++) begin
      checkOutput("acc_valid", {63'd0, outValid}, 64'd1);
      checkOutput("acc_res", res, accExp[i]);
      @(posedge clock);
      #1;
    end

    $display("[TB] backpressure stream");
    popBase = popCount;
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(2'b00, 1'($urandom_range(1)), 1'b0, W'($urandom), W'($urandom));
      end
      begin
        repeat (6) @(posedge clock);
        #3 readyMode = 2;
        repeat (3) @(posedge clock);
        #2 readyMode = 0;
      end
    join
    inValid = 1'b0;
    waitDrain();
    checkOutput("stream_count", 64'(popCount - popBase), 64'd8);
    runSingle("acc_after_add", 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1FD, 1'b0, 1'b0);

    $display("[TB] reset with operations in flight");
    for (int i = 0; i < 5; i++) applyStimulus(2'b00, 1'b0, 1'b0, W'($urandom), W'($urandom));
    inValid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset_valid", {63'd0, outValid}, 64'd0);
    checkOutput("midreset_res", res, 64'd0);
    checkOutput("midreset_co_ov", {62'd0, co, ov}, 64'd0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
    runSingle("acc_after_reset", 2'b10, 1'b0, 1'b0, 32'h5, 32'h0, 32'h5, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    readyMode = 1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(2'($urandom_range(3)), ($urandom_range(7) == 0), 1'($urandom_range(1)),
                    pickOperand(), pickOperand());
      if ($urandom_range(3) == 0) begin
        inValid = 1'b0;
        @(posedge clock);
        #1;
      end
    end
    inValid = 1'b0;
    readyMode = 0;
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
